// File: rtl/deparser_queue_merge_pkg.sv
// Shared definitions for the queue tag the parser inserts into the PHV and
// the deparser-side merge that decodes it.
package deparser_queue_merge_pkg;

    localparam int unsigned Q_TAG_POS = 141;
    localparam int unsigned Q_TAG_W   = 4;
    localparam int unsigned Q_IDX_W   = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } merge_state_t;

    typedef struct packed {
        logic               valid;
        logic [Q_IDX_W-1:0] idx;
    } q_tag_dec_t;

    // One-hot queue tag to queue index; valid is low for zero or multi-hot tags.
    function automatic q_tag_dec_t decode_q_tag(input logic [Q_TAG_W-1:0] tag);
        q_tag_dec_t d;
        d.valid = 1'b1;
        d.idx   = '0;
        case (tag)
            4'b0001: d.idx = 2'd0;
            4'b0010: d.idx = 2'd1;
            4'b0100: d.idx = 2'd2;
            4'b1000: d.idx = 2'd3;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout is valid whenever empty is low.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam int unsigned CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]          depth;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr       = wr_en && (depth != CNT_W'(DEPTH));
    assign do_rd       = rd_en && !empty;
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= CNT_W'(DEPTH - 1));
    assign dout        = mem[rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous write and read keep depth unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + CNT_W'(1);
                2'b01:   depth <= depth - CNT_W'(1);
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/deparser_queue_merge.sv
// Merges the four data-cache queues back into one AXI-Stream, choosing the
// queue from the one-hot tag carried in each processed PHV.
module deparser_queue_merge
    import deparser_queue_merge_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned PKT_HDR_LEN          = 1024,
    parameter int unsigned C_NUM_QUEUES         = 4,
    parameter int unsigned Q_TAG_LSB            = Q_TAG_POS
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,

    input  logic [PKT_HDR_LEN-1:0]            phv_in,
    input  logic                              phv_in_valid,
    output logic                              phv_in_ready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_0,
    input  logic                              s_axis_tlast_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_1,
    input  logic                              s_axis_tlast_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_2,
    input  logic                              s_axis_tlast_2,
    input  logic                              s_axis_tvalid_2,
    output logic                              s_axis_tready_2,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_3,
    input  logic                              s_axis_tlast_3,
    input  logic                              s_axis_tvalid_3,
    output logic                              s_axis_tready_3,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,

    output logic [PKT_HDR_LEN-1:0]            phv_out,
    output logic                              phv_out_valid,
    output logic                              tag_err,
    output logic [31:0]                       pkt_cnt
);

    localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

    logic [C_S_AXIS_DATA_WIDTH-1:0]  q_tdata [C_NUM_QUEUES];
    logic [C_S_AXIS_TUSER_WIDTH-1:0] q_tuser [C_NUM_QUEUES];
    logic [KEEP_W-1:0]               q_tkeep [C_NUM_QUEUES];
    logic [C_NUM_QUEUES-1:0]         q_tlast;
    logic [C_NUM_QUEUES-1:0]         q_tvalid;
    logic [C_NUM_QUEUES-1:0]         q_tready;

    logic [PKT_HDR_LEN-1:0]          fifo_dout;
    logic                            fifo_empty;
    logic                            fifo_nearly_full;

    merge_state_t                    state;
    merge_state_t                    next_state;
    q_tag_dec_t                      tag_dec;
    logic [Q_IDX_W-1:0]              rr;
    logic [Q_IDX_W-1:0]              cur_q;
    logic [Q_IDX_W-1:0]              sel_q;
    logic                            first;
    logic                            fifo_pop;
    logic                            beat_hs;
    logic                            pkt_done;

    assign q_tdata  = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3};
    assign q_tuser  = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3};
    assign q_tkeep  = '{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3};
    assign q_tlast  = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign q_tvalid = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

    assign s_axis_tready_0 = q_tready[0];
    assign s_axis_tready_1 = q_tready[1];
    assign s_axis_tready_2 = q_tready[2];
    assign s_axis_tready_3 = q_tready[3];

    assign phv_in_ready  = !fifo_nearly_full;
    assign tag_dec       = decode_q_tag(fifo_dout[Q_TAG_LSB +: Q_TAG_W]);
    assign phv_out_valid = first && m_axis_tvalid;

    fallthrough_small_fifo #(
        .WIDTH          (PKT_HDR_LEN),
        .MAX_DEPTH_BITS (4)
    ) u_phv_fifo (
        .clk         (axis_clk),
        .reset       (!aresetn),
        .din         (phv_in),
        .wr_en       (phv_in_valid && phv_in_ready),
        .rd_en       (fifo_pop),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    // State register.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, queue select and the combinational output mux.
    always_comb begin
        next_state    = state;
        fifo_pop      = 1'b0;
        beat_hs       = 1'b0;
        pkt_done      = 1'b0;
        tag_err       = 1'b0;
        sel_q         = rr;
        q_tready      = '0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = ST_FLUSH;
                    if (tag_dec.valid) begin
                        sel_q = tag_dec.idx;
                    end else begin
                        tag_err = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                m_axis_tdata    = q_tdata[cur_q];
                m_axis_tuser    = q_tuser[cur_q];
                m_axis_tkeep    = q_tkeep[cur_q];
                m_axis_tlast    = q_tlast[cur_q];
                m_axis_tvalid   = q_tvalid[cur_q];
                q_tready[cur_q] = m_axis_tready;
                if (q_tvalid[cur_q] && m_axis_tready) begin
                    beat_hs = 1'b1;
                    if (q_tlast[cur_q]) begin
                        pkt_done   = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // PHV latch, first-beat flag, round-robin expectation and packet count.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            phv_out <= '0;
            cur_q   <= '0;
            first   <= 1'b0;
            rr      <= '0;
            pkt_cnt <= '0;
        end else begin
            if (fifo_pop) begin
                phv_out <= fifo_dout;
                cur_q   <= sel_q;
                first   <= 1'b1;
            end else if (beat_hs) begin
                first   <= 1'b0;
            end
            if (pkt_done) begin
                pkt_cnt <= pkt_cnt + 32'd1;
                rr      <= Q_IDX_W'(cur_q + Q_IDX_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_deparser_queue_merge.sv
// Scoreboard bench for deparser_queue_merge: queue sources, PHV driver and an
// output monitor that pops expected beats as they leave the merged stream.
module tb_deparser_queue_merge;
    import deparser_queue_merge_pkg::*;

    localparam int unsigned DW = 256;
    localparam int unsigned UW = 128;
    localparam int unsigned KW = 32;
    localparam int unsigned HW = 1024;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
        logic          first;
        logic [HW-1:0] phv;
        int            exp_edge;
    } sb_t;

    logic            axis_clk = 1'b0;
    logic            aresetn;
    logic [HW-1:0]   phv_in;
    logic            phv_in_valid;
    logic            phv_in_ready;
    logic [DW-1:0]   s_tdata [4];
    logic [UW-1:0]   s_tuser [4];
    logic [KW-1:0]   s_tkeep [4];
    logic [3:0]      s_tlast;
    logic [3:0]      s_tvalid;
    logic [3:0]      s_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [UW-1:0]   m_axis_tuser;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [HW-1:0]   phv_out;
    logic            phv_out_valid;
    logic            tag_err;
    logic [31:0]     pkt_cnt;

    always #5 axis_clk = ~axis_clk;

    deparser_queue_merge dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .phv_in_ready    (phv_in_ready),
        .s_axis_tdata_0  (s_tdata[0]), .s_axis_tuser_0 (s_tuser[0]), .s_axis_tkeep_0 (s_tkeep[0]),
        .s_axis_tlast_0  (s_tlast[0]), .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(s_tready[0]),
        .s_axis_tdata_1  (s_tdata[1]), .s_axis_tuser_1 (s_tuser[1]), .s_axis_tkeep_1 (s_tkeep[1]),
        .s_axis_tlast_1  (s_tlast[1]), .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(s_tready[1]),
        .s_axis_tdata_2  (s_tdata[2]), .s_axis_tuser_2 (s_tuser[2]), .s_axis_tkeep_2 (s_tkeep[2]),
        .s_axis_tlast_2  (s_tlast[2]), .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(s_tready[2]),
        .s_axis_tdata_3  (s_tdata[3]), .s_axis_tuser_3 (s_tuser[3]), .s_axis_tkeep_3 (s_tkeep[3]),
        .s_axis_tlast_3  (s_tlast[3]), .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(s_tready[3]),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .phv_out         (phv_out),
        .phv_out_valid   (phv_out_valid),
        .tag_err         (tag_err),
        .pkt_cnt         (pkt_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          exp_pkts = 0;
    int          exp_tag_err = 0;
    int          tag_err_cnt = 0;
    int          lat_e0 = 0;
    logic [1:0]  model_rr = 2'd0;
    logic [3:0]  en = 4'hf;
    logic        toggle_mode = 1'b0;
    beat_t       srcq [4][$];
    sb_t         sb [$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Queue sources and output monitor: observe on the falling edge, update after the rising edge.
    logic [3:0]    pop;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_pov;
    sb_t           mon_e;
    always begin
        @(negedge axis_clk);
        pop = aresetn ? (s_tvalid & s_tready) : 4'b0;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (tag_err) tag_err_cnt++;
            if (prev_stall) begin
                chk("stall_tvalid", m_axis_tvalid, 1'b1);
                chk("stall_tdata", m_axis_tdata, prev_data);
                chk("stall_tlast", m_axis_tlast, prev_last);
                chk("stall_phv_out_valid", phv_out_valid, prev_pov);
            end
            if (toggle_mode && m_axis_tvalid) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("s_tready_%0d", i), s_tready[i], (i == 2) ? m_axis_tready : 1'b0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("tdata", m_axis_tdata, mon_e.data);
                    chk("tuser", m_axis_tuser, mon_e.user);
                    chk("tkeep", m_axis_tkeep, mon_e.keep);
                    chk("tlast", m_axis_tlast, mon_e.last);
                    chk("phv_out_valid", phv_out_valid, mon_e.first);
                    if (mon_e.first) begin
                        for (int c = 0; c < 4; c++)
                            chk($sformatf("phv_out_%0d", c), phv_out[c*256 +: 256], mon_e.phv[c*256 +: 256]);
                    end
                    if (mon_e.exp_edge >= 0) chk("beat_edge", cyc + 1, mon_e.exp_edge);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_pov   = phv_out_valid;
        end
        @(posedge axis_clk);
        #2;
        for (int i = 0; i < 4; i++)
            if (pop[i] && srcq[i].size() != 0) srcq[i].delete(0);
        if (toggle_mode) m_axis_tready = ~m_axis_tready;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && srcq[i].size() != 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = srcq[i][0].data;
                s_tuser[i]  = srcq[i][0].user;
                s_tkeep[i]  = srcq[i][0].keep;
                s_tlast[i]  = srcq[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    end

    // Drives one PHV (call at posedge+1), then loads its beats and expectations.
    task automatic send_pkt(input logic [3:0] tag, input int nbeats, input int lat_idx);
        logic [HW-1:0] phv;
        beat_t         b;
        sb_t           e;
        int            q;
        int            n;
        for (int w = 0; w < int'(HW / 32); w++) phv[w*32 +: 32] = $urandom;
        phv[Q_TAG_POS +: 4] = tag;
        phv_in       = phv;
        phv_in_valid = 1'b1;
        n = 0;
        @(negedge axis_clk);
        while (!phv_in_ready && n < 200) begin
            n++;
            @(negedge axis_clk);
        end
        if (!phv_in_ready) begin
            chk("phv_accept_timeout", phv_in_ready, 1'b1);
            phv_in_valid = 1'b0;
            return;
        end
        @(posedge axis_clk);
        #1;
        phv_in_valid = 1'b0;
        n_acc++;
        if (lat_idx == 0) lat_e0 = cyc;
        if ($countones(tag) == 1) begin
            q = 0;
            for (int k = 0; k < 4; k++) if (tag[k]) q = k;
        end else begin
            q = int'(model_rr);
            exp_tag_err++;
        end
        model_rr = 2'((q + 1) % 4);
        exp_pkts++;
        for (int k = 0; k < nbeats; k++) begin
            for (int w = 0; w < int'(DW / 32); w++) b.data[w*32 +: 32] = $urandom;
            for (int w = 0; w < int'(UW / 32); w++) b.user[w*32 +: 32] = $urandom;
            b.keep = $urandom;
            b.last = (k == nbeats - 1);
            srcq[q].push_back(b);
            e.data     = b.data;
            e.user     = b.user;
            e.keep     = b.keep;
            e.last     = b.last;
            e.first    = (k == 0);
            e.phv      = phv;
            e.exp_edge = (lat_idx >= 0) ? (lat_e0 + 2 + 2 * lat_idx) : -1;
            sb.push_back(e);
        end
    endtask

    // Waits for the scoreboard to empty (bounded), ending on a falling edge.
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge axis_clk);
            n++;
        end
        chk("drain_remaining", sb.size(), 0);
        repeat (3) @(negedge axis_clk);
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        aresetn       = 1'b0;
        phv_in        = '0;
        phv_in_valid  = 1'b0;
        m_axis_tready = 1'b1;
        s_tvalid      = '0;
        s_tlast       = '0;
        for (int i = 0; i < 4; i++) begin
            s_tdata[i] = '0;
            s_tuser[i] = '0;
            s_tkeep[i] = '0;
        end
        repeat (3) step();
        aresetn = 1'b1;
        @(negedge axis_clk);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_s_tready", s_tready, 4'b0);
        chk("rst_phv_out", phv_out[255:0], 256'd0);
        chk("rst_phv_out_valid", phv_out_valid, 1'b0);
        chk("rst_tag_err", tag_err, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk("rst_phv_in_ready", phv_in_ready, 1'b1);

        // Four one-beat packets, one per queue, back to back.
        step();
        send_pkt(4'b0001, 1, 0);
        send_pkt(4'b0010, 1, 1);
        send_pkt(4'b0100, 1, 2);
        send_pkt(4'b1000, 1, 3);
        wait_drain();
        chk("t1_pkt_cnt", pkt_cnt, 32'(exp_pkts));
        chk("t1_tag_err", tag_err_cnt, exp_tag_err);
        chk("t1_rr", dut.rr, model_rr);

        // Three-beat packet on queue 2 with toggling downstream ready.
        step();
        toggle_mode   = 1'b1;
        m_axis_tready = 1'b1;
        send_pkt(4'b0100, 3, -1);
        wait_drain();
        step();
        toggle_mode   = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge axis_clk);
        chk("t2_rr", dut.rr, model_rr);
        chk("t2_pkt_cnt", pkt_cnt, 32'(exp_pkts));

        // One-hot tag disagreeing with rr: tag wins, no error.
        step();
        send_pkt(4'b0010, 1, -1);
        wait_drain();
        chk("t3_rr", dut.rr, model_rr);
        chk("t3_tag_err", tag_err_cnt, exp_tag_err);

        // Bring rr to 1, then a zero tag falls back to rr.
        step();
        send_pkt(4'b1000, 1, -1);
        send_pkt(4'b0001, 1, -1);
        wait_drain();
        step();
        send_pkt(4'b0000, 1, -1);
        wait_drain();
        chk("t4_rr", dut.rr, model_rr);
        chk("t4_tag_err", tag_err_cnt, exp_tag_err);

        // Multi-hot tag also falls back to rr.
        step();
        send_pkt(4'b0110, 2, -1);
        wait_drain();
        chk("t5_rr", dut.rr, model_rr);
        chk("t5_tag_err", tag_err_cnt, exp_tag_err);
        chk("t5_pkt_cnt", pkt_cnt, 32'(exp_pkts));

        // Fill the PHV buffer while queue 0 is stalled, then release it.
        step();
        en   = 4'b1110;
        acc0 = n_acc;
        fork
            begin
                for (int i = 0; i < 17; i++) send_pkt(4'b0001, 1, -1);
            end
            begin
                n = 0;
                while (phv_in_ready && n < 100) begin
                    @(negedge axis_clk);
                    n++;
                end
                chk("fill_phv_in_ready", phv_in_ready, 1'b0);
                chk("fill_accepted", n_acc - acc0, 16);
                repeat (4) @(negedge axis_clk);
                chk("fill_ready_held", phv_in_ready, 1'b0);
                step();
                en = 4'hf;
            end
        join
        wait_drain();
        chk("fill_total", n_acc - acc0, 17);
        chk("fill_pkt_cnt", pkt_cnt, 32'(exp_pkts));
        chk("fill_phv_in_ready_back", phv_in_ready, 1'b1);

        // Reset in the middle of a stalled packet.
        step();
        m_axis_tready = 1'b0;
        send_pkt(4'b0100, 3, -1);
        n = 0;
        @(negedge axis_clk);
        while (!m_axis_tvalid && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        chk("rst2_pre_tvalid", m_axis_tvalid, 1'b1);
        step();
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        sb.delete();
        model_rr = 2'd0;
        exp_pkts = 0;
        @(negedge axis_clk);
        chk("rst2_state", dut.state, ST_IDLE);
        chk("rst2_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst2_s_tready", s_tready, 4'b0);
        chk("rst2_phv_out", phv_out[255:0], 256'd0);
        chk("rst2_phv_out_any", |phv_out, 1'b0);
        chk("rst2_phv_out_valid", phv_out_valid, 1'b0);
        chk("rst2_tag_err", tag_err, 1'b0);
        chk("rst2_pkt_cnt", pkt_cnt, 32'd0);
        chk("rst2_rr", dut.rr, 2'd0);
        chk("rst2_phv_in_ready", phv_in_ready, 1'b1);

        // After reset a zero tag must go to queue 0.
        step();
        m_axis_tready = 1'b1;
        send_pkt(4'b0000, 1, -1);
        wait_drain();
        chk("post_rst_pkt_cnt", pkt_cnt, 32'(exp_pkts));
        chk("post_rst_rr", dut.rr, model_rr);
        chk("post_rst_tag_err", tag_err_cnt, exp_tag_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
